// File: rtl/idu_rf_pipe_fwd.sv
// Register-read stage for one issue pipe: drives source tags to the RF and resolves operands from EX/CDB forwarding or RF data.
// Latency: one cycle from accept to out_vld; operand values are combinational from fwd_*/RF in the cycle the entry is held.
// Backpressure: in_rdy = !stage_vld | out_rdy; on a stall each operand is captured once and frozen until the entry leaves.
module idu_rf_pipe_fwd #(
    parameter int XLEN   = 64,
    parameter int PREG_W = 6,
    parameter int NSRC   = 2,
    parameter int NFWD   = 8,
    parameter int PLD_W  = 96
) (
    input  logic                    clk,
    input  logic                    rst_clk,
    input  logic                    rtu_global_flush,
    input  logic                    in_vld,
    output logic                    in_rdy,
    input  logic [PLD_W-1:0]        in_payload,
    input  logic [NSRC-1:0]         in_psrc_vld,
    input  logic [NSRC*PREG_W-1:0]  in_psrc,
    input  logic [NFWD-1:0]         fwd_vld,
    input  logic [NFWD*PREG_W-1:0]  fwd_preg,
    input  logic [NFWD*XLEN-1:0]    fwd_result,
    output logic [NSRC-1:0]         x_rf_preg_psrc_vld,
    output logic [NSRC*PREG_W-1:0]  x_rf_preg_psrc,
    input  logic [NSRC*XLEN-1:0]    x_rf_psrc_value,
    output logic                    out_vld,
    input  logic                    out_rdy,
    output logic [PLD_W-1:0]        out_payload,
    output logic [NSRC-1:0]         out_psrc_vld,
    output logic [NSRC*XLEN-1:0]    out_psrc_value
);

    logic                   stage_vld;
    logic [PLD_W-1:0]       payload_q;
    logic [NSRC-1:0]        psrc_vld_q;
    logic [NSRC*PREG_W-1:0] psrc_q;
    logic [NSRC-1:0]        cap_q;
    logic [NSRC*XLEN-1:0]   capv_q;

    logic [NSRC-1:0]        fwd_hit;
    logic [NSRC*XLEN-1:0]   fwd_val;
    logic [NSRC*XLEN-1:0]   res_val;
    logic                   accept;
    logic                   stall;
    logic                   drain;

    assign in_rdy = !stage_vld || out_rdy;
    assign accept = in_vld && in_rdy;
    assign stall  = stage_vld && !out_rdy;
    assign drain  = stage_vld && out_rdy;

    // Scan from highest index down so the lowest matching source is the one left standing.
    always_comb begin
        fwd_hit = '0;
        fwd_val = '0;
        for (int i = 0; i < NSRC; i++) begin
            for (int k = NFWD - 1; k >= 0; k--) begin
                if (fwd_vld[k] && (fwd_preg[k*PREG_W +: PREG_W] == psrc_q[i*PREG_W +: PREG_W])) begin
                    fwd_hit[i]               = 1'b1;
                    fwd_val[i*XLEN +: XLEN]  = fwd_result[k*XLEN +: XLEN];
                end
            end
        end
    end

    always_comb begin
        res_val = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (!psrc_vld_q[i]) begin
                res_val[i*XLEN +: XLEN] = '0;
            end else if (cap_q[i]) begin
                res_val[i*XLEN +: XLEN] = capv_q[i*XLEN +: XLEN];
            end else if (fwd_hit[i]) begin
                res_val[i*XLEN +: XLEN] = fwd_val[i*XLEN +: XLEN];
            end else begin
                res_val[i*XLEN +: XLEN] = x_rf_psrc_value[i*XLEN +: XLEN];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_clk) begin
        if (!rst_clk) begin
            stage_vld  <= 1'b0;
            payload_q  <= '0;
            psrc_vld_q <= '0;
            psrc_q     <= '0;
            cap_q      <= '0;
            capv_q     <= '0;
        end else if (rtu_global_flush) begin
            stage_vld  <= 1'b0;
            payload_q  <= '0;
            psrc_vld_q <= '0;
            psrc_q     <= '0;
            cap_q      <= '0;
            capv_q     <= '0;
        end else if (accept) begin
            stage_vld  <= 1'b1;
            payload_q  <= in_payload;
            psrc_vld_q <= in_psrc_vld;
            psrc_q     <= in_psrc;
            cap_q      <= '0;
            capv_q     <= '0;
        end else if (stall) begin
            // Freeze each operand on the first stalled edge; forwarding sources may vanish afterwards.
            for (int i = 0; i < NSRC; i++) begin
                if (!cap_q[i]) begin
                    cap_q[i]                <= 1'b1;
                    capv_q[i*XLEN +: XLEN]  <= res_val[i*XLEN +: XLEN];
                end
            end
        end else if (drain) begin
            stage_vld  <= 1'b0;
            payload_q  <= '0;
            psrc_vld_q <= '0;
            psrc_q     <= '0;
            cap_q      <= '0;
            capv_q     <= '0;
        end
    end

    assign out_vld            = stage_vld;
    assign out_payload        = payload_q;
    assign x_rf_preg_psrc_vld = psrc_vld_q;
    assign x_rf_preg_psrc     = psrc_q;
    assign out_psrc_vld       = psrc_vld_q;
    assign out_psrc_value     = res_val;

endmodule

// File: tb/tb_idu_rf_pipe_fwd.sv
// Directed bench for idu_rf_pipe_fwd: expected transfers queued at issue, popped on out_vld & out_rdy.
module tb_idu_rf_pipe_fwd;

    localparam int XLEN   = 64;
    localparam int PREG_W = 6;
    localparam int NSRC   = 2;
    localparam int NFWD   = 8;
    localparam int PLD_W  = 96;

    logic                   clk;
    logic                   rst_clk;
    logic                   rtu_global_flush;
    logic                   in_vld;
    logic                   in_rdy;
    logic [PLD_W-1:0]       in_payload;
    logic [NSRC-1:0]        in_psrc_vld;
    logic [NSRC*PREG_W-1:0] in_psrc;
    logic [NFWD-1:0]        fwd_vld;
    logic [NFWD*PREG_W-1:0] fwd_preg;
    logic [NFWD*XLEN-1:0]   fwd_result;
    logic [NSRC-1:0]        x_rf_preg_psrc_vld;
    logic [NSRC*PREG_W-1:0] x_rf_preg_psrc;
    logic [NSRC*XLEN-1:0]   x_rf_psrc_value;
    logic                   out_vld;
    logic                   out_rdy;
    logic [PLD_W-1:0]       out_payload;
    logic [NSRC-1:0]        out_psrc_vld;
    logic [NSRC*XLEN-1:0]   out_psrc_value;

    typedef struct packed {
        logic [PLD_W-1:0]     pld;
        logic [NSRC-1:0]      sv;
        logic [NSRC*XLEN-1:0] val;
    } exp_t;

    exp_t        sb[$];
    logic [63:0] rf [64];
    int          n_assert;
    int          n_fail;

    idu_rf_pipe_fwd #(
        .XLEN(XLEN), .PREG_W(PREG_W), .NSRC(NSRC), .NFWD(NFWD), .PLD_W(PLD_W)
    ) dut (
        .clk               (clk),
        .rst_clk           (rst_clk),
        .rtu_global_flush  (rtu_global_flush),
        .in_vld            (in_vld),
        .in_rdy            (in_rdy),
        .in_payload        (in_payload),
        .in_psrc_vld       (in_psrc_vld),
        .in_psrc           (in_psrc),
        .fwd_vld           (fwd_vld),
        .fwd_preg          (fwd_preg),
        .fwd_result        (fwd_result),
        .x_rf_preg_psrc_vld(x_rf_preg_psrc_vld),
        .x_rf_preg_psrc    (x_rf_preg_psrc),
        .x_rf_psrc_value   (x_rf_psrc_value),
        .out_vld           (out_vld),
        .out_rdy           (out_rdy),
        .out_payload       (out_payload),
        .out_psrc_vld      (out_psrc_vld),
        .out_psrc_value    (out_psrc_value)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Register file model: same-cycle read of whatever tags the stage presents.
    always_comb begin
        x_rf_psrc_value = '0;
        for (int i = 0; i < NSRC; i++)
            x_rf_psrc_value[i*XLEN +: XLEN] = rf[x_rf_preg_psrc[i*PREG_W +: PREG_W]];
    end

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_fwd(input int k, input logic [PREG_W-1:0] tag, input logic [XLEN-1:0] d);
        fwd_vld[k]                    = 1'b1;
        fwd_preg[k*PREG_W +: PREG_W]  = tag;
        fwd_result[k*XLEN +: XLEN]    = d;
    endtask

    task automatic clr_fwd();
        fwd_vld    = '0;
        fwd_preg   = '0;
        fwd_result = '0;
    endtask

    task automatic drive(input logic [PLD_W-1:0] p, input logic [NSRC-1:0] sv,
                         input logic [PREG_W-1:0] s0, input logic [PREG_W-1:0] s1);
        in_vld      = 1'b1;
        in_payload  = p;
        in_psrc_vld = sv;
        in_psrc     = {s1, s0};
    endtask

    task automatic push(input logic [PLD_W-1:0] p, input logic [NSRC-1:0] sv,
                        input logic [XLEN-1:0] v0, input logic [XLEN-1:0] v1);
        exp_t e;
        e.pld = p;
        e.sv  = sv;
        e.val = {v1, v0};
        sb.push_back(e);
    endtask

    // Compare any transfer happening this cycle, then advance one edge.
    task automatic cyc();
        exp_t e;
        #1;
        if (out_vld === 1'b1 && out_rdy === 1'b1) begin
            if (sb.size() == 0) begin
                chk("xfer_unexpected", 128'(out_payload), 128'(0));
            end else begin
                e = sb.pop_front();
                chk("xfer_payload", 128'(out_payload), 128'(e.pld));
                chk("xfer_psrc_vld", 128'(out_psrc_vld), 128'(e.sv));
                chk("xfer_values", 128'(out_psrc_value), 128'(e.val));
            end
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        for (int r = 0; r < 64; r++) rf[r] = 64'h0;
        rst_clk          = 1'b0;
        rtu_global_flush = 1'b0;
        in_vld           = 1'b0;
        in_payload       = '0;
        in_psrc_vld      = '0;
        in_psrc          = '0;
        out_rdy          = 1'b1;
        clr_fwd();
        #12 rst_clk = 1'b1;
        @(posedge clk); #1;

        // Reset / idle state
        chk("rst_out_vld", 128'(out_vld), 128'(0));
        chk("rst_in_rdy", 128'(in_rdy), 128'(1));
        chk("rst_payload", 128'(out_payload), 128'(0));
        chk("rst_rf_vld", 128'(x_rf_preg_psrc_vld), 128'(0));
        chk("rst_rf_tag", 128'(x_rf_preg_psrc), 128'(0));
        chk("rst_psrc_vld", 128'(out_psrc_vld), 128'(0));
        chk("rst_values", 128'(out_psrc_value), 128'(0));

        // Basic accept, RF-only operands
        rf[5] = 64'h11;
        rf[9] = 64'h22;
        drive(96'hA1, 2'b11, 6'd5, 6'd9);
        push(96'hA1, 2'b11, 64'h11, 64'h22);
        cyc();
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        #1;
        chk("i1_out_vld", 128'(out_vld), 128'(1));
        chk("i1_rf_tags", 128'(x_rf_preg_psrc), 128'({6'd9, 6'd5}));
        chk("i1_values", 128'(out_psrc_value), {64'h22, 64'h11});

        // Forwarding priority on the held entry, before any stall edge
        set_fwd(0, 6'd5, 64'hA);
        set_fwd(5, 6'd5, 64'hB);
        #1;
        chk("prio_fwd0", 128'(out_psrc_value[63:0]), 128'(64'hA));
        fwd_vld[0] = 1'b0;
        #1;
        chk("prio_fwd5", 128'(out_psrc_value[63:0]), 128'(64'hB));
        clr_fwd();
        #1;
        chk("prio_rf_again", 128'(out_psrc_value[63:0]), 128'(64'h11));

        // Release I1 while accepting I2 (src0 invalid); its src1 will be captured from fwd
        out_rdy = 1'b1;
        drive(96'hA2, 2'b10, 6'd5, 6'd9);
        push(96'hA2, 2'b10, 64'h0, 64'hDEAD);
        cyc();
        in_vld  = 1'b0;
        out_rdy = 1'b0;
        set_fwd(1, 6'd5, 64'h77);
        #1;
        chk("inv_src_value", 128'(out_psrc_value[63:0]), 128'(0));
        chk("inv_psrc_vld", 128'(out_psrc_vld), 128'(2'b10));

        // Stall capture: fwd present only in first held cycle
        clr_fwd();
        set_fwd(2, 6'd9, 64'hDEAD);
        #1;
        chk("stall_a_value", 128'(out_psrc_value[127:64]), 128'(64'hDEAD));
        chk("stall_a_in_rdy", 128'(in_rdy), 128'(0));
        cyc();
        clr_fwd();
        rf[9] = 64'h0;
        set_fwd(0, 6'd9, 64'hBEEF);
        #1;
        chk("stall_b_value", 128'(out_psrc_value[127:64]), 128'(64'hDEAD));
        chk("stall_b_in_rdy", 128'(in_rdy), 128'(0));
        chk("stall_b_payload", 128'(out_payload), 128'(96'hA2));
        cyc();
        clr_fwd();
        #1;
        chk("stall_c_value", 128'(out_psrc_value[127:64]), 128'(64'hDEAD));
        chk("stall_c_out_vld", 128'(out_vld), 128'(1));
        chk("stall_c_in_rdy", 128'(in_rdy), 128'(0));
        cyc();

        // Back-to-back: I2 transfers in the first iteration's cycle
        out_rdy = 1'b1;
        for (int j = 0; j < 4; j++) begin
            rf[10+j] = 64'h1000 + 64'(j);
            rf[20+j] = 64'h2000 + 64'(j);
        end
        #1;
        chk("b2b_in_rdy", 128'(in_rdy), 128'(1));
        for (int j = 0; j < 4; j++) begin
            drive(96'hB0 + 96'(j), 2'b11, 6'(10 + j), 6'(20 + j));
            push(96'hB0 + 96'(j), 2'b11, 64'h1000 + 64'(j), 64'h2000 + 64'(j));
            cyc();
            chk("b2b_out_vld", 128'(out_vld), 128'(1));
            chk("b2b_payload", 128'(out_payload), 128'(96'hB0 + 96'(j)));
        end
        in_vld = 1'b0;
        cyc();
        chk("drain_out_vld", 128'(out_vld), 128'(0));
        chk("drain_payload", 128'(out_payload), 128'(0));
        chk("drain_rf_vld", 128'(x_rf_preg_psrc_vld), 128'(0));
        chk("drain_rf_tag", 128'(x_rf_preg_psrc), 128'(0));
        chk("drain_values", 128'(out_psrc_value), 128'(0));

        // Flush coinciding with accept
        drive(96'hF1, 2'b11, 6'd5, 6'd9);
        rtu_global_flush = 1'b1;
        #1;
        chk("flush_cyc_in_rdy", 128'(in_rdy), 128'(1));
        cyc();
        rtu_global_flush = 1'b0;
        in_vld           = 1'b0;
        #1;
        chk("flush_out_vld", 128'(out_vld), 128'(0));
        chk("flush_payload", 128'(out_payload), 128'(0));
        chk("flush_rf_vld", 128'(x_rf_preg_psrc_vld), 128'(0));
        chk("flush_values", 128'(out_psrc_value), 128'(0));

        // Flush during a stall, then a fresh entry on the same tag sees new RF data
        rf[30]  = 64'h3030;
        out_rdy = 1'b0;
        drive(96'hC1, 2'b01, 6'd30, 6'd0);
        cyc();
        in_vld = 1'b0;
        cyc();
        rf[30] = 64'h5555;
        #1;
        chk("cap_before_flush", 128'(out_psrc_value[63:0]), 128'(64'h3030));
        rtu_global_flush = 1'b1;
        cyc();
        rtu_global_flush = 1'b0;
        #1;
        chk("sflush_out_vld", 128'(out_vld), 128'(0));
        chk("sflush_values", 128'(out_psrc_value), 128'(0));
        drive(96'hC2, 2'b01, 6'd30, 6'd0);
        cyc();
        in_vld = 1'b0;
        #1;
        chk("post_flush_value", 128'(out_psrc_value[63:0]), 128'(64'h5555));

        // Async reset between edges while stalled
        cyc();
        #3;
        rst_clk = 1'b0;
        #1;
        chk("arst_out_vld", 128'(out_vld), 128'(0));
        chk("arst_in_rdy", 128'(in_rdy), 128'(1));
        chk("arst_values", 128'(out_psrc_value), 128'(0));
        chk("arst_payload", 128'(out_payload), 128'(0));
        #3;
        rst_clk = 1'b1;
        out_rdy = 1'b1;
        cyc();
        chk("post_arst_out_vld", 128'(out_vld), 128'(0));
        chk("sb_empty", 128'(sb.size()), 128'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
